alu_exec_stage: RTL and testbench

- Execute stage that consumes the two register-file read operands (SR1, SR2) plus the current IR, and performs LC-3 ADD / AND / NOT with an imm5 option.
- Result, destination code and load strobe are registered and presented to the register-file write port via a valid/ready handshake.
- Holds the NZP condition-code register and produces BEN for BR instructions.
- Sits directly downstream of the register file and feeds its BusIn / LD_REG / DR inputs.

---
 rtl/alu_exec_stage.sv | 98 +++++++++
 tb/tb_alu_exec_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// LC-3 execute stage: ADD/AND/NOT with imm5 option, NZP condition codes and BEN,
// presented to the register-file write port through a one-entry valid/ready register.
module alu_exec_stage #(
   parameter int         WIDTH    = 16,
   parameter logic [2:0] CC_RESET = 3'b010
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      IR,
   input  logic [WIDTH-1:0] SR1_in,
   input  logic [WIDTH-1:0] SR2_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALU_out,
   output logic [2:0]       DR_out,
   output logic             LD_REG_out,
   output logic [2:0]       NZP,
   output logic             BEN
);

   typedef enum logic [3:0] {
      OP_BR  = 4'b0000,
      OP_ADD = 4'b0001,
      OP_AND = 4'b0101,
      OP_NOT = 4'b1001
   } opcode_t;

   logic             accept;
   logic             drain;
   logic [WIDTH-1:0] b_op;
   logic [WIDTH-1:0] result;
   logic             ld_reg;
   logic             cc_write;
   logic             is_br;
   logic [2:0]       nzp_new;
   logic             unused_ir;

   // SR1/SR2 register selects are resolved upstream by the register file
   assign unused_ir = ^IR[8:6];

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign drain    = out_valid && out_ready;

   always_comb begin
      b_op     = IR[5] ? {{(WIDTH-5){IR[4]}}, IR[4:0]} : SR2_in;
      result   = SR1_in;
      ld_reg   = 1'b0;
      cc_write = 1'b0;
      is_br    = 1'b0;
      case (IR[15:12])
         OP_ADD: begin
            result   = SR1_in + b_op;
            ld_reg   = 1'b1;
            cc_write = 1'b1;
         end
         OP_AND: begin
            result   = SR1_in & b_op;
            ld_reg   = 1'b1;
            cc_write = 1'b1;
         end
         OP_NOT: begin
            result   = ~SR1_in;
            ld_reg   = 1'b1;
            cc_write = 1'b1;
         end
         OP_BR: is_br = 1'b1;
         default: ;
      endcase
      nzp_new[2] = result[WIDTH-1];
      nzp_new[1] = (result == '0);
      nzp_new[0] = !nzp_new[2] && !nzp_new[1];
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         out_valid  <= 1'b0;
         ALU_out    <= '0;
         DR_out     <= '0;
         LD_REG_out <= 1'b0;
         NZP        <= CC_RESET;
         BEN        <= 1'b0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         ALU_out    <= result;
         DR_out     <= IR[11:9];
         LD_REG_out <= ld_reg;
         if (cc_write) NZP <= nzp_new;
         // BR samples the condition codes as they stand before this edge
         if (is_br)    BEN <= |(IR[11:9] & NZP);
      end else if (drain) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage: reset, ALU ops, BR/BEN,
// back-pressure, streaming and asynchronous reset while a result is pending.
module tb_alu_exec_stage;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] IR;
   logic [15:0] SR1_in;
   logic [15:0] SR2_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] ALU_out;
   logic [2:0]  DR_out;
   logic        LD_REG_out;
   logic [2:0]  NZP;
   logic        BEN;

   int n_cmp = 0;
   int n_err = 0;

   alu_exec_stage #(.WIDTH(16), .CC_RESET(3'b010)) dut (
      .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
      .IR(IR), .SR1_in(SR1_in), .SR2_in(SR2_in),
      .out_valid(out_valid), .out_ready(out_ready), .ALU_out(ALU_out),
      .DR_out(DR_out), .LD_REG_out(LD_REG_out), .NZP(NZP), .BEN(BEN)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b0; in_valid = 1'b1; IR = 16'h1261; SR1_in = 16'h7FFF; SR2_in = '0; out_ready = 1'b1;
      step(); step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      n_cmp++; if (NZP !== 3'b010) begin n_err++; $display("FAIL rst_nzp got %b exp 010", NZP); end
      n_cmp++; if (BEN !== 1'b0) begin n_err++; $display("FAIL rst_ben got %b exp 0", BEN); end
      n_cmp++; if (ALU_out !== 16'h0000) begin n_err++; $display("FAIL rst_alu got %h exp 0000", ALU_out); end
      n_cmp++; if (DR_out !== 3'd0 || LD_REG_out !== 1'b0) begin n_err++; $display("FAIL rst_dr_ld got %0d/%b exp 0/0", DR_out, LD_REG_out); end
      Reset = 1'b1; in_valid = 1'b0;
      step(); step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_out_valid got %b exp 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_add_imm();
      in_valid = 1'b1; IR = 16'h1261; SR1_in = 16'h7FFF; SR2_in = 16'h5555; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %b exp 1", out_valid); end
      n_cmp++; if (ALU_out !== 16'h8000) begin n_err++; $display("FAIL add_alu got %h exp 8000", ALU_out); end
      n_cmp++; if (DR_out !== 3'd1 || LD_REG_out !== 1'b1) begin n_err++; $display("FAIL add_dr_ld got %0d/%b exp 1/1", DR_out, LD_REG_out); end
      n_cmp++; if (NZP !== 3'b100) begin n_err++; $display("FAIL add_nzp got %b exp 100", NZP); end
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got %b exp 0", out_valid); end
      n_cmp++; if (ALU_out !== 16'h8000) begin n_err++; $display("FAIL drain_hold got %h exp 8000", ALU_out); end
   endtask

   task automatic test_and_br();
      in_valid = 1'b1; IR = 16'h5020; SR1_in = 16'hFFFF; SR2_in = 16'hFFFF; out_ready = 1'b1;
      step();
      n_cmp++; if (ALU_out !== 16'h0000 || NZP !== 3'b010) begin n_err++; $display("FAIL and_res got %h/%b exp 0000/010", ALU_out, NZP); end
      n_cmp++; if (DR_out !== 3'd0 || LD_REG_out !== 1'b1) begin n_err++; $display("FAIL and_dr_ld got %0d/%b exp 0/1", DR_out, LD_REG_out); end
      IR = 16'h0400; SR1_in = 16'h0000;
      step();
      n_cmp++; if (BEN !== 1'b1) begin n_err++; $display("FAIL brz_ben got %b exp 1", BEN); end
      n_cmp++; if (LD_REG_out !== 1'b0 || DR_out !== 3'd2 || out_valid !== 1'b1) begin n_err++; $display("FAIL brz_ld_dr got %b/%0d/%b exp 0/2/1", LD_REG_out, DR_out, out_valid); end
      IR = 16'h0800; SR1_in = 16'h1234;
      step();
      in_valid = 1'b0;
      n_cmp++; if (BEN !== 1'b0) begin n_err++; $display("FAIL brn_ben got %b exp 0", BEN); end
      n_cmp++; if (ALU_out !== 16'h1234 || DR_out !== 3'd4 || NZP !== 3'b010) begin n_err++; $display("FAIL brn_pass got %h/%0d/%b exp 1234/4/010", ALU_out, DR_out, NZP); end
      step();
   endtask

   task automatic test_backpressure();
      in_valid = 1'b1; IR = 16'h927F; SR1_in = 16'h00FF; SR2_in = 16'h0000; out_ready = 1'b0;
      step();
      n_cmp++; if (ALU_out !== 16'hFF00 || NZP !== 3'b100 || DR_out !== 3'd1) begin n_err++; $display("FAIL not_res got %h/%b/%0d exp ff00/100/1", ALU_out, NZP, DR_out); end
      IR = 16'h1422; SR1_in = 16'h0010;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
         n_cmp++; if (out_valid !== 1'b1 || ALU_out !== 16'hFF00 || DR_out !== 3'd1) begin n_err++; $display("FAIL bp_hold[%0d] got %b/%h/%0d exp 1/ff00/1", i, out_valid, ALU_out, DR_out); end
         step();
      end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
      step();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || ALU_out !== 16'h0012 || DR_out !== 3'd2 || NZP !== 3'b001) begin n_err++; $display("FAIL bp_second got %b/%h/%0d/%b exp 1/0012/2/001", out_valid, ALU_out, DR_out, NZP); end
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b exp 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] v_ir  [6] = '{16'h1601, 16'h1801, 16'h1A01, 16'h1C01, 16'h5E3F, 16'hE200};
      logic [15:0] v_sr1 [6] = '{16'hFFFF, 16'h1234, 16'h8000, 16'h0003, 16'hA5A5, 16'h4321};
      logic [15:0] v_sr2 [6] = '{16'h0001, 16'h1111, 16'h0001, 16'hFFFE, 16'h0000, 16'h0000};
      logic [15:0] e_alu [6] = '{16'h0000, 16'h2345, 16'h8001, 16'h0001, 16'hA5A5, 16'h4321};
      logic [2:0]  e_dr  [6] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
      logic        e_ld  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [2:0]  e_nzp [6] = '{3'b010, 3'b001, 3'b100, 3'b001, 3'b100, 3'b100};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; IR = v_ir[i]; SR1_in = v_sr1[i]; SR2_in = v_sr2[i];
         step();
         n_cmp++;
         if (out_valid !== 1'b1 || ALU_out !== e_alu[i] || DR_out !== e_dr[i] || LD_REG_out !== e_ld[i] || NZP !== e_nzp[i]) begin
            n_err++;
            $display("FAIL stream[%0d] got v=%b alu=%h dr=%0d ld=%b nzp=%b exp v=1 alu=%h dr=%0d ld=%b nzp=%b",
                     i, out_valid, ALU_out, DR_out, LD_REG_out, NZP, e_alu[i], e_dr[i], e_ld[i], e_nzp[i]);
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_midtransfer();
      in_valid = 1'b1; IR = 16'h1261; SR1_in = 16'h0000; SR2_in = 16'h0000; out_ready = 1'b0;
      step();
      n_cmp++; if (out_valid !== 1'b1 || NZP !== 3'b001) begin n_err++; $display("FAIL pre_rst got %b/%b exp 1/001", out_valid, NZP); end
      #1 Reset = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || NZP !== 3'b010 || ALU_out !== 16'h0000 || LD_REG_out !== 1'b0) begin n_err++; $display("FAIL async_rst got %b/%b/%h/%b exp 0/010/0000/0", out_valid, NZP, ALU_out, LD_REG_out); end
      in_valid = 1'b0;
      step();
      Reset = 1'b1;
      step();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst got %b/%b exp 0/1", out_valid, in_ready); end
   endtask

   initial begin
      test_reset();
      test_add_imm();
      test_and_br();
      test_backpressure();
      test_back_to_back();
      test_reset_midtransfer();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
